// File: rtl/itch_pkg.sv
// Shared definitions for the ITCH message parser.
// Holds the message-type and side byte codes, the only two body lengths the
// parser decodes, the byte offsets of every field inside a message (offset 0
// is the type byte), the parser state enum and the decoded order record.
package itch_pkg;

  localparam logic [7:0] ITCH_ADD = 8'h41;
  localparam logic [7:0] ITCH_DEL = 8'h44;
  localparam logic [7:0] ITCH_BUY = 8'h42;

  localparam logic [15:0] ADD_LEN = 16'd36;
  localparam logic [15:0] DEL_LEN = 16'd19;

  // Offsets 3-4 carry the tracking number, which nothing downstream needs.
  localparam logic [15:0] OFF_LOCATE_LO = 16'd1;
  localparam logic [15:0] OFF_LOCATE_HI = 16'd2;
  localparam logic [15:0] OFF_TS_LO     = 16'd5;
  localparam logic [15:0] OFF_TS_HI     = 16'd10;
  localparam logic [15:0] OFF_REF_LO    = 16'd11;
  localparam logic [15:0] OFF_REF_HI    = 16'd18;
  localparam logic [15:0] OFF_SIDE      = 16'd19;
  localparam logic [15:0] OFF_SHARES_LO = 16'd20;
  localparam logic [15:0] OFF_SHARES_HI = 16'd23;
  localparam logic [15:0] OFF_STOCK_LO  = 16'd24;
  localparam logic [15:0] OFF_STOCK_HI  = 16'd31;
  localparam logic [15:0] OFF_PRICE_LO  = 16'd32;
  localparam logic [15:0] OFF_PRICE_HI  = 16'd35;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    TYPE,
    BODY,
    SKIP
  } parseState_t;

  typedef struct packed {
    logic [15:0] locate;
    logic [47:0] timestamp;
    logic [63:0] orderRef;
    logic        side;
    logic [31:0] shares;
    logic [63:0] stock;
    logic [31:0] price;
  } itch_order_t;

  // True when a body offset falls inside the inclusive field range [lo, hi].
  function automatic logic inRange(input logic [15:0] idx,
                                   input logic [15:0] lo,
                                   input logic [15:0] hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/itch_msg_parser_if.sv
// Stream/record bundle between the UDP parser, the ITCH parser and the
// order-book stage.
//   dataValidIn/dataIn      : ITCH byte stream into the parser
//   addValidOut/delValidOut : one-cycle record strobes
//   locateOut..priceOut     : decoded record fields
//   msgErrOut               : one-cycle error strobe
//   msgCntOut/errCntOut     : free-running wrap-around counters
// slave is the parser side, master is the stream source / record consumer.
interface itch_msg_parser_if #(
  parameter int CNT_W = 32
);

  logic             dataValidIn;
  logic [7:0]       dataIn;
  logic             addValidOut;
  logic             delValidOut;
  logic [15:0]      locateOut;
  logic [47:0]      timestampOut;
  logic [63:0]      orderRefOut;
  logic             sideOut;
  logic [31:0]      sharesOut;
  logic [63:0]      stockOut;
  logic [31:0]      priceOut;
  logic             msgErrOut;
  logic [CNT_W-1:0] msgCntOut;
  logic [CNT_W-1:0] errCntOut;

  modport slave (
    input  dataValidIn, dataIn,
    output addValidOut, delValidOut, locateOut, timestampOut, orderRefOut,
           sideOut, sharesOut, stockOut, priceOut, msgErrOut, msgCntOut,
           errCntOut
  );

  modport master (
    output dataValidIn, dataIn,
    input  addValidOut, delValidOut, locateOut, timestampOut, orderRefOut,
           sideOut, sharesOut, stockOut, priceOut, msgErrOut, msgCntOut,
           errCntOut
  );

endinterface

// File: rtl/itch_msg_parser.sv
// ITCH message parser.
// Walks the MoldUDP64 message-block stream (2-byte big-endian length, then
// the message), decodes Add Order and Order Delete messages into a
// registered record and skips every other message type by its length.
// A mid-message input stall of IDLE_TIMEOUT cycles aborts the message.
// Ports:
//   clkIn  : 250MHz clock
//   rstBIn : asynchronous active-low reset
//   bus    : stream in, record/strobes/counters out (itch_msg_parser_if.slave)
module itch_msg_parser
  import itch_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clkIn,
  input  logic                  rstBIn,
  itch_msg_parser_if.slave      bus
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);

  parseState_t       state;
  logic [15:0]       len;
  logic [15:0]       byteIdx;
  logic [7:0]        msgType;
  logic [IDLE_W-1:0] idleCnt;
  itch_order_t       shadow;
  itch_order_t       nextShadow;
  itch_order_t       rec;
  logic              addValid;
  logic              delValid;
  logic              msgErr;
  logic [CNT_W-1:0]  msgCnt;
  logic [CNT_W-1:0]  errCnt;

  logic              accept;
  logic [7:0]        byteIn;
  logic              lastByte;
  logic              timeoutHit;

  // Every field is a shift register that takes its bytes MSB first, so each
  // field is fully overwritten by the bytes of the current message and the
  // record can be published on the last-byte edge with the final byte merged
  // in combinationally, without an extra pipeline cycle.
  always_comb begin
    accept     = bus.dataValidIn;
    byteIn     = bus.dataIn;
    lastByte   = (byteIdx == (len - 16'd1));
    timeoutHit = !accept && (state != LEN_HI) && (idleCnt == IDLE_LAST);
    nextShadow = shadow;
    if (state == BODY && accept) begin
      if (inRange(byteIdx, OFF_LOCATE_LO, OFF_LOCATE_HI))
        nextShadow.locate = {shadow.locate[7:0], byteIn};
      if (inRange(byteIdx, OFF_TS_LO, OFF_TS_HI))
        nextShadow.timestamp = {shadow.timestamp[39:0], byteIn};
      if (inRange(byteIdx, OFF_REF_LO, OFF_REF_HI))
        nextShadow.orderRef = {shadow.orderRef[55:0], byteIn};
      if (byteIdx == OFF_SIDE)
        nextShadow.side = (byteIn == ITCH_BUY);
      if (inRange(byteIdx, OFF_SHARES_LO, OFF_SHARES_HI))
        nextShadow.shares = {shadow.shares[23:0], byteIn};
      if (inRange(byteIdx, OFF_STOCK_LO, OFF_STOCK_HI))
        nextShadow.stock = {shadow.stock[55:0], byteIn};
      if (inRange(byteIdx, OFF_PRICE_LO, OFF_PRICE_HI))
        nextShadow.price = {shadow.price[23:0], byteIn};
    end
  end

  // Parser FSM, capture registers, record outputs and counters.
  // The timeout branch is only reachable with no byte offered, so a byte
  // arriving on the expiry cycle is always consumed normally. Strobes default
  // low each cycle; msgErr and the record strobes are set on mutually
  // exclusive paths, so they can never coincide.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state    <= LEN_HI;
      len      <= '0;
      byteIdx  <= '0;
      msgType  <= '0;
      idleCnt  <= '0;
      shadow   <= '0;
      rec      <= '0;
      addValid <= 1'b0;
      delValid <= 1'b0;
      msgErr   <= 1'b0;
      msgCnt   <= '0;
      errCnt   <= '0;
    end else begin
      addValid <= 1'b0;
      delValid <= 1'b0;
      msgErr   <= 1'b0;

      if (accept)
        idleCnt <= '0;
      else if (state != LEN_HI && idleCnt != IDLE_MAX)
        idleCnt <= idleCnt + 1'b1;

      if (timeoutHit) begin
        state   <= LEN_HI;
        idleCnt <= '0;
        msgErr  <= 1'b1;
        errCnt  <= errCnt + 1'b1;
      end else if (accept) begin
        case (state)
          LEN_HI: begin
            len[15:8] <= byteIn;
            state     <= LEN_LO;
          end
          LEN_LO: begin
            len[7:0] <= byteIn;
            if ({len[15:8], byteIn} == 16'd0) begin
              state <= LEN_HI;
            end else begin
              byteIdx <= '0;
              state   <= TYPE;
            end
          end
          TYPE: begin
            msgType <= byteIn;
            byteIdx <= 16'd1;
            if (len == 16'd1) begin
              msgCnt <= msgCnt + 1'b1;
              state  <= LEN_HI;
            end else if ((byteIn == ITCH_ADD && len == ADD_LEN) ||
                         (byteIn == ITCH_DEL && len == DEL_LEN)) begin
              state <= BODY;
            end else if (byteIn == ITCH_ADD || byteIn == ITCH_DEL) begin
              msgErr <= 1'b1;
              errCnt <= errCnt + 1'b1;
              state  <= SKIP;
            end else begin
              state <= SKIP;
            end
          end
          BODY: begin
            shadow  <= nextShadow;
            byteIdx <= byteIdx + 16'd1;
            if (lastByte) begin
              state  <= LEN_HI;
              msgCnt <= msgCnt + 1'b1;
              // Deletes refresh only the shared fields; the Add-only fields
              // keep describing the last Add record.
              if (msgType == ITCH_ADD) begin
                rec      <= nextShadow;
                addValid <= 1'b1;
              end else begin
                rec.locate    <= nextShadow.locate;
                rec.timestamp <= nextShadow.timestamp;
                rec.orderRef  <= nextShadow.orderRef;
                delValid      <= 1'b1;
              end
            end
          end
          SKIP: begin
            byteIdx <= byteIdx + 16'd1;
            if (lastByte) begin
              state  <= LEN_HI;
              msgCnt <= msgCnt + 1'b1;
            end
          end
          default: state <= LEN_HI;
        endcase
      end
    end
  end

  assign bus.addValidOut  = addValid;
  assign bus.delValidOut  = delValid;
  assign bus.msgErrOut    = msgErr;
  assign bus.locateOut    = rec.locate;
  assign bus.timestampOut = rec.timestamp;
  assign bus.orderRefOut  = rec.orderRef;
  assign bus.sideOut      = rec.side;
  assign bus.sharesOut    = rec.shares;
  assign bus.stockOut     = rec.stock;
  assign bus.priceOut     = rec.price;
  assign bus.msgCntOut    = msgCnt;
  assign bus.errCntOut    = errCnt;

endmodule
